// File: rtl/cnn_pkg.sv
// Shared helpers for the CNN layer blocks (conv, linear, pooling):
// a width-agnostic compare-select and a packed-channel slice.
// Operands travel as CNN_MAX_W-bit zero-extended vectors, and the real
// sample width is passed in as an argument.
package cnn_pkg;

    localparam int CNN_MAX_W = 64;    // widest sample any layer uses
    localparam int CNN_BUS_W = 1024;  // widest packed channel bus

    // a > b over the low w bits. Two's-complement order is obtained by
    // flipping the sign bit and then comparing unsigned.
    function automatic logic cnn_gt(input logic [CNN_MAX_W-1:0] a,
                                    input logic [CNN_MAX_W-1:0] b,
                                    input logic                 is_signed,
                                    input int                   w);
        logic [CNN_MAX_W-1:0] msb;
        msb = is_signed ? (CNN_MAX_W'(1) << (w - 1)) : '0;
        return (a ^ msb) > (b ^ msb);
    endfunction

    // Max of two samples. The first operand wins a tie, so the selection is
    // deterministic.
    function automatic logic [CNN_MAX_W-1:0] cnn_max_sel(input logic [CNN_MAX_W-1:0] a,
                                                         input logic [CNN_MAX_W-1:0] b,
                                                         input logic                 is_signed,
                                                         input int                   w);
        return cnn_gt(b, a, is_signed, w) ? b : a;
    endfunction

    // Channel c of a packed bus, where channel c sits at [c*w +: w].
    function automatic logic [CNN_MAX_W-1:0] cnn_ch_slice(input logic [CNN_BUS_W-1:0] bus,
                                                          input int                   c,
                                                          input int                   w);
        logic [CNN_MAX_W-1:0] mask;
        mask = (w >= CNN_MAX_W) ? '1 : ((CNN_MAX_W'(1) << w) - CNN_MAX_W'(1));
        return CNN_MAX_W'(bus >> (c * w)) & mask;
    endfunction

endpackage

// File: rtl/maxpool_cmp.sv
// Two-input max for one channel. Purely combinational, built on the shared
// compare-select. Ties return a.
import cnn_pkg::*;

module maxpool_cmp #(
    parameter int DATA_WIDTH = 24,
    parameter int SIGNED     = 1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    // Select the larger sample under the configured signedness.
    always_comb begin
        y = DATA_WIDTH'(cnn_max_sel(CNN_MAX_W'(a), CNN_MAX_W'(b), SIGNED != 0, DATA_WIDTH));
    end

endmodule

// File: rtl/maxpool_nch.sv
// 2x2 / stride-2 max pooling over a raster-order stream of CH_NUM packed channels.
// Even rows: each horizontal pair max is parked in a half-width line buffer.
// Odd rows: the pair max is merged with the parked entry and emitted one
// cycle after the odd-column sample is accepted.
// An odd trailing column or row is consumed and discarded.
// Optional: define MAXPOOL_RELU_EN to clamp negative outputs to zero when SIGNED=1.
import cnn_pkg::*;

module maxpool_nch #(
    parameter int DATA_WIDTH  = 24,
    parameter int CH_NUM      = 3,
    parameter int DISP_WIDTH  = 26,
    parameter int DISP_HEIGHT = 26,
    parameter int SIGNED      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CH_NUM*DATA_WIDTH-1:0] data_in,
    input  logic                         data_in_valid,
    output logic [CH_NUM*DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    output logic                         frame_done
);

    localparam int PW       = DISP_WIDTH / 2;
    localparam int PH       = DISP_HEIGHT / 2;
    localparam int CW       = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;
    localparam int RW       = (DISP_HEIGHT > 1) ? $clog2(DISP_HEIGHT) : 1;
    localparam int LBW      = (PW > 1) ? $clog2(PW) : 1;
    localparam int LAST_COL = PW * 2 - 1;
    localparam int LAST_ROW = PH * 2 - 1;

    typedef logic [CH_NUM-1:0][DATA_WIDTH-1:0] pix_t;

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    pix_t           pend_q, pend_d;            // even-column sample awaiting its partner
    pix_t           data_out_q, data_out_d;
    logic           data_out_valid_q, data_out_valid_d;
    logic           frame_done_q, frame_done_d;

    pix_t           lb_q [PW];                 // pair maxima of the last even row
    logic [LBW-1:0] lb_idx;
    logic           lb_we;
    pix_t           lb_rd;

    pix_t           din_ch, pair_max, quad_max, res;

    assign lb_idx = LBW'(col_q >> 1);
    assign lb_rd  = lb_q[lb_idx];

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign din_ch[c] = DATA_WIDTH'(cnn_ch_slice(CNN_BUS_W'(data_in), c, DATA_WIDTH));

        maxpool_cmp #(.DATA_WIDTH(DATA_WIDTH), .SIGNED(SIGNED)) u_pair (
            .a (pend_q[c]),
            .b (din_ch[c]),
            .y (pair_max[c])
        );

        maxpool_cmp #(.DATA_WIDTH(DATA_WIDTH), .SIGNED(SIGNED)) u_quad (
            .a (lb_rd[c]),
            .b (pair_max[c]),
            .y (quad_max[c])
        );
    end

    // Optional ReLU on the pooled value. It sits ahead of the output register,
    // so latency does not change.
    always_comb begin
        res = quad_max;
`ifdef MAXPOOL_RELU_EN
        if (SIGNED != 0) begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (quad_max[c][DATA_WIDTH-1]) res[c] = '0;
            end
        end
`endif
    end

    // Raster position. It advances only on accepted samples and wraps
    // straight into the next frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (data_in_valid) begin
            if (col_q == CW'(DISP_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(DISP_HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Route each accepted sample to one of three places: the pending register,
    // a line-buffer write, or the output stage.
    always_comb begin
        pend_d           = pend_q;
        lb_we            = 1'b0;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        frame_done_d     = 1'b0;
        if (data_in_valid) begin
            if (!col_q[0]) begin
                pend_d = din_ch;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                data_out_d       = res;
                data_out_valid_d = 1'b1;
                frame_done_d     = (row_q == RW'(LAST_ROW)) && (col_q == CW'(LAST_COL));
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q            <= '0;
            row_q            <= '0;
            pend_q           <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            col_q            <= col_d;
            row_q            <= row_d;
            pend_q           <= pend_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            frame_done_q     <= frame_done_d;
        end
    end

    // Line buffer storage. It has no reset because every entry is rewritten
    // on an even row before it is read.
    always_ff @(posedge clk) begin
        if (lb_we) lb_q[lb_idx] <= pair_max;
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign frame_done     = frame_done_q;

endmodule

// File: doc/maxpool_nch.md
MAXPOOL_NCH -- requirements
Module: maxpool_nch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, bit width of one channel sample.
REQ-002 SHALL have parameter CH_NUM, default 3, number of parallel channels.
REQ-003 SHALL have parameter DISP_WIDTH, default 26, input feature-map width in pixels.
REQ-004 SHALL have parameter DISP_HEIGHT, default 26, input feature-map height in rows.
REQ-005 SHALL have parameter SIGNED, default 1; 1 means two's-complement compare, 0 means unsigned compare.
REQ-006 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port data_in, input, CH_NUM*DATA_WIDTH, channel c in bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port data_in_valid, input, 1, data_in is accepted on each cycle this is high (no backpressure).
REQ-010 SHALL have port data_out, output, CH_NUM*DATA_WIDTH, pooled pixel, same channel packing as data_in.
REQ-011 SHALL have port data_out_valid, output, 1, one-cycle strobe per pooled pixel.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-013 SHALL perform 2x2 max pooling with stride 2 on a raster-order stream (row-major, left to right), independently per channel.
REQ-014 SHALL track column counter col (0..DISP_WIDTH-1) and row counter row (0..DISP_HEIGHT-1), advanced only on accepted samples.
REQ-015 SHALL, on even rows, store max(pixel[col-1], pixel[col]) at every odd col into a line buffer of DISP_WIDTH/2 entries per channel.
REQ-016 SHALL, on odd rows at odd col, output max(line buffer entry, pixel[col-1], pixel[col]) with data_out_valid high exactly one cycle after that sample is accepted.
REQ-017 SHALL use floor semantics: an odd last column or odd last row is consumed and discarded; output size is (DISP_WIDTH/2) x (DISP_HEIGHT/2).
REQ-018 SHALL tolerate arbitrary gaps in data_in_valid; counters, line buffer and pending column register hold during gaps.
REQ-019 SHALL wrap col to 0 and increment row after col = DISP_WIDTH-1; wrap row to 0 after row = DISP_HEIGHT-1 so the next frame starts with no idle cycle.
REQ-020 SHALL assert frame_done with the output for row DISP_HEIGHT/2*2-1, col DISP_WIDTH/2*2-1.
REQ-021 SHALL choose the first operand on equal values (ties deterministic, value identical).
REQ-022 SHALL hold data_out at its last value when data_out_valid is low.

Reset
REQ-023 SHALL, while rst_n is low, clear col, row, data_out, data_out_valid and frame_done to 0 asynchronously.
REQ-024 SHALL, on reset mid-frame, discard the partial frame; the first sample after release is pixel (0,0); line buffer contents need not be cleared.

Configuration
REQ-025 SHALL, when macro MAXPOOL_RELU_EN is defined, clamp each output channel that is negative (SIGNED=1) to zero before registering; output latency unchanged.
REQ-026 SHALL, when MAXPOOL_RELU_EN is undefined, output the raw maximum; with SIGNED=0 the macro has no effect.

Structure
REQ-027 SHALL take the shared compare-select function and the packed-channel slice helper from package cnn_pkg, also used by conv and linear layers.
REQ-028 SHALL instantiate one sub-module maxpool_cmp (two-input max, parametrised DATA_WIDTH and SIGNED) per comparison per channel; counters and line buffer stay in maxpool_nch.

Verification
REQ-029 SHALL cover: 4x4, CH_NUM=1, unsigned, pixels 0..15 in raster order -> outputs 5,7,13,15, frame_done with 15.
REQ-030 SHALL cover: 26x26, CH_NUM=3, continuous valid -> exactly 169 valid strobes per frame, each matching a software model.
REQ-031 SHALL cover: 5x5 frame -> 4 outputs, column 4 and row 4 ignored; second frame back-to-back yields correct 4 outputs.
REQ-032 SHALL cover: SIGNED=1, window {-3,-8,-1,-2} -> -1; with MAXPOOL_RELU_EN -> 0.
REQ-033 SHALL cover: random valid gaps (50% duty) on a 10x10 frame -> 25 outputs identical to gapless run.
REQ-034 SHALL cover: rst_n pulsed low at pixel 40 of a 10x10 frame -> outputs and valid 0 immediately, next full frame correct.
